exception_sequencer: RTL and testbench
======================================

EXCEPTION_SEQUENCER -- requirements
Module: exception_sequencer

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-003 SHALL have port exc_req, input, 1, MEM-stage synchronous exception pending.
REQ-004 SHALL have port exc_code, input, 5, MIPS ExcCode of exc_req.
REQ-005 SHALL have port exc_badvaddr, input, 32, faulting address for AdEL/AdES/TLB codes.
REQ-006 SHALL have port exc_tlb_refill, input, 1, exc_req is a TLB refill.
REQ-007 SHALL have port int_pending, input, 1, OR of (Cause.IP & Status.IM).
REQ-008 SHALL have port eret_req, input, 1, ERET at MEM stage.
REQ-009 SHALL have ports status_ie, status_exl, status_bev, input, 1 each, CP0 Status bits.
REQ-010 SHALL have port cp0_epc, input, 32, current EPC (ERET target).
REQ-011 SHALL have ports vic_inst_addr (32), vic_is_delayslot (1), exp_asid (8), inputs, victim-instruction detector outputs.
REQ-012 SHALL have port mem_busy, input, 1, outstanding data-bus transaction.
REQ-013 SHALL have port pipe_stall, output, 1, freeze all pipeline registers.
REQ-014 SHALL have port pipe_flush, output, 1, clear IF/ID, ID/EXE, EXE/MEM.
REQ-015 SHALL have ports pc_redirect (1) and pc_target (32), outputs, PC load strobe and value.
REQ-016 SHALL have ports cp0_exc_we (1), cp0_epc_o (32), cp0_bd (1), cp0_exccode (5), cp0_badvaddr (32), cp0_badvaddr_we (1), cp0_asid (8), outputs, CP0 exception write.
REQ-017 SHALL have ports exl_set, exl_clr, output, 1 each.

Function
REQ-018 SHALL implement states IDLE, DRAIN, COMMIT, REDIRECT.
REQ-019 SHALL in IDLE select by priority: exc_req > (int_pending & status_ie & ~status_exl) > eret_req; kind ERET only if no higher event.
REQ-020 SHALL on any selected event in IDLE latch kind, exc_code (interrupt: 5'h00), badvaddr, tlb_refill, vic_inst_addr, vic_is_delayslot, exp_asid, cp0_epc; then go DRAIN if mem_busy else COMMIT.
REQ-021 SHALL stay in DRAIN while mem_busy=1; go COMMIT the cycle after mem_busy=0 is sampled.
REQ-022 SHALL in COMMIT assert pipe_flush for exactly one cycle; for exceptions/interrupts also cp0_exc_we=1 and exl_set=1; for ERET exl_clr=1, cp0_exc_we=0.
REQ-023 SHALL drive cp0_epc_o = latched vic_is_delayslot ? vic_inst_addr-4 : vic_inst_addr, 32-bit modulo; cp0_bd = latched delayslot.
REQ-024 SHALL assert cp0_badvaddr_we only for exc_code in {4,5,2,3,1}.
REQ-025 SHALL in REDIRECT assert pc_redirect one cycle with pc_target = ERET: latched cp0_epc; else base + offset, base = status_bev ? 32'hBFC00200 : 32'h80000000, offset = (tlb_refill & ~status_exl-at-latch) ? 0x000 : 0x180; then IDLE.
REQ-026 SHALL assert pipe_stall = (state != IDLE) | (IDLE & selected event), combinationally.
REQ-027 SHALL ignore all requests outside IDLE; no queueing.
REQ-028 SHALL give latency: event in IDLE cycle N with mem_busy=0 -> COMMIT N+1, REDIRECT N+2, IDLE N+3.
REQ-029 SHALL hold all strobe outputs 0 outside the states named above; data outputs SHALL be 0 when their strobe is 0.
REQ-030 SHALL treat simultaneous exc_req and int_pending as exception only; interrupt re-sampled after return to IDLE.

Reset
REQ-031 SHALL on rst_n=0 asynchronously enter IDLE and clear all latched fields and outputs to 0.
REQ-032 SHALL on reset mid-sequence abandon the event with no CP0 write or redirect after rst_n deasserts.

Structure
REQ-033 SHALL place state enum, ExcCode constants and vector base/offset constants in shared package cpu_exc_pkg.
REQ-034 SHALL instantiate one sub-module exc_vector_gen (combinational target computation); remainder flat.

Verification
REQ-035 SHALL test: exc_req code 5'h04, badvaddr 0x00400003, vic 0xBFC00010, ds=0, bev=1, mem_busy=0 -> COMMIT N+1 epc 0xBFC00010 bd=0 badvaddr_we=1; REDIRECT N+2 target 0xBFC00380.
REQ-036 SHALL test: interrupt, ie=1 exl=0, vic 0x80001004 ds=1, bev=0 -> epc 0x80001000, bd=1, exccode 0, target 0x80000180.
REQ-037 SHALL test: exc_req with mem_busy=1 for 4 cycles -> DRAIN 4 cycles, COMMIT exactly one cycle after mem_busy falls, stall high throughout.
REQ-038 SHALL test: exc_req code 8 and int_pending same cycle -> exccode 8; eret_req with cp0_epc 0x80002000 -> exl_clr, no cp0_exc_we, target 0x80002000.
REQ-039 SHALL test: TLB refill exl=0 bev=0 -> target 0x80000000; with exl=1 -> 0x80000180.
REQ-040 SHALL test: rst_n low during DRAIN -> outputs 0 immediately, no redirect after release.

Source files
------------

// File: rtl/cpu_exc_pkg.sv
// Shared exception-sequencer types and constants: FSM states, event kinds,
// MIPS ExcCodes and exception vector base/offset values.
package cpu_exc_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StCommit,
        StRedirect
    } exc_state_e;

    typedef enum logic [1:0] {
        KindNone,
        KindExc,
        KindInt,
        KindEret
    } exc_kind_e;

    localparam logic [4:0] ExcInt  = 5'h00;
    localparam logic [4:0] ExcMod  = 5'h01;
    localparam logic [4:0] ExcTlbl = 5'h02;
    localparam logic [4:0] ExcTlbs = 5'h03;
    localparam logic [4:0] ExcAdel = 5'h04;
    localparam logic [4:0] ExcAdes = 5'h05;

    localparam logic [31:0] VecBaseBev    = 32'hBFC0_0200;
    localparam logic [31:0] VecBaseNorm   = 32'h8000_0000;
    localparam logic [31:0] VecOffRefill  = 32'h0000_0000;
    localparam logic [31:0] VecOffGeneral = 32'h0000_0180;

    // Address-error and TLB exceptions carry a faulting address for BadVAddr.
    function automatic logic has_badvaddr(input logic [4:0] code);
        return (code == ExcMod) || (code == ExcTlbl) || (code == ExcTlbs) ||
               (code == ExcAdel) || (code == ExcAdes);
    endfunction

endpackage

// File: rtl/exc_vector_gen.sv
// Combinational redirect-target computation: ERET return address or
// exception vector (BEV-selected base plus refill/general offset).
module exc_vector_gen
    import cpu_exc_pkg::*;
(
    input  logic        is_eret,
    input  logic [31:0] eret_epc,
    input  logic        tlb_refill,
    input  logic        exl_at_latch,
    input  logic        status_bev,
    output logic [31:0] target
);

    logic [31:0] base;
    logic [31:0] offset;

    always_comb begin
        base   = status_bev ? VecBaseBev : VecBaseNorm;
        // A refill taken while already at EXL goes through the general vector.
        offset = (tlb_refill && !exl_at_latch) ? VecOffRefill : VecOffGeneral;
        target = is_eret ? eret_epc : base + offset;
    end

endmodule

// File: rtl/exception_sequencer.sv
// MEM-stage exception/interrupt/ERET sequencer: selects one event, drains the
// data bus, commits the CP0 update with a pipeline flush, then redirects the PC.
module exception_sequencer
    import cpu_exc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exc_req,
    input  logic [4:0]  exc_code,
    input  logic [31:0] exc_badvaddr,
    input  logic        exc_tlb_refill,
    input  logic        int_pending,
    input  logic        eret_req,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic        status_bev,
    input  logic [31:0] cp0_epc,
    input  logic [31:0] vic_inst_addr,
    input  logic        vic_is_delayslot,
    input  logic [7:0]  exp_asid,
    input  logic        mem_busy,
    output logic        pipe_stall,
    output logic        pipe_flush,
    output logic        pc_redirect,
    output logic [31:0] pc_target,
    output logic        cp0_exc_we,
    output logic [31:0] cp0_epc_o,
    output logic        cp0_bd,
    output logic [4:0]  cp0_exccode,
    output logic [31:0] cp0_badvaddr,
    output logic        cp0_badvaddr_we,
    output logic [7:0]  cp0_asid,
    output logic        exl_set,
    output logic        exl_clr
);

    exc_state_e  state_q, state_d;
    exc_kind_e   sel_kind, kind_q;
    logic [4:0]  code_q;
    logic [31:0] badvaddr_q;
    logic        refill_q;
    logic        exl_q;
    logic [31:0] vic_q;
    logic        ds_q;
    logic [7:0]  asid_q;
    logic [31:0] epc_q;
    logic        load;
    logic [31:0] vec_target;

    always_comb begin
        sel_kind = KindNone;
        if (exc_req) begin
            sel_kind = KindExc;
        end else if (int_pending && status_ie && !status_exl) begin
            sel_kind = KindInt;
        end else if (eret_req) begin
            sel_kind = KindEret;
        end
    end

    assign load = (state_q == StIdle) && (sel_kind != KindNone);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            kind_q     <= KindNone;
            code_q     <= '0;
            badvaddr_q <= '0;
            refill_q   <= 1'b0;
            exl_q      <= 1'b0;
            vic_q      <= '0;
            ds_q       <= 1'b0;
            asid_q     <= '0;
            epc_q      <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                kind_q     <= sel_kind;
                code_q     <= (sel_kind == KindExc) ? exc_code : ExcInt;
                badvaddr_q <= exc_badvaddr;
                // Refill only meaningful when the event really is exc_req.
                refill_q   <= exc_req && exc_tlb_refill;
                exl_q      <= status_exl;
                vic_q      <= vic_inst_addr;
                ds_q       <= vic_is_delayslot;
                asid_q     <= exp_asid;
                epc_q      <= cp0_epc;
            end
        end
    end

    exc_vector_gen u_exc_vector_gen (
        .is_eret      (kind_q == KindEret),
        .eret_epc     (epc_q),
        .tlb_refill   (refill_q),
        .exl_at_latch (exl_q),
        .status_bev   (status_bev),
        .target       (vec_target)
    );

    always_comb begin
        state_d         = state_q;
        pipe_stall      = 1'b0;
        pipe_flush      = 1'b0;
        pc_redirect     = 1'b0;
        pc_target       = '0;
        cp0_exc_we      = 1'b0;
        cp0_epc_o       = '0;
        cp0_bd          = 1'b0;
        cp0_exccode     = '0;
        cp0_badvaddr    = '0;
        cp0_badvaddr_we = 1'b0;
        cp0_asid        = '0;
        exl_set         = 1'b0;
        exl_clr         = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (sel_kind != KindNone) begin
                    pipe_stall = 1'b1;
                    state_d    = mem_busy ? StDrain : StCommit;
                end
            end
            StDrain: begin
                pipe_stall = 1'b1;
                if (!mem_busy) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                pipe_stall = 1'b1;
                pipe_flush = 1'b1;
                if (kind_q == KindEret) begin
                    exl_clr = 1'b1;
                end else begin
                    cp0_exc_we  = 1'b1;
                    exl_set     = 1'b1;
                    cp0_epc_o   = ds_q ? vic_q - 32'd4 : vic_q;
                    cp0_bd      = ds_q;
                    cp0_exccode = code_q;
                    cp0_asid    = asid_q;
                    if (has_badvaddr(code_q)) begin
                        cp0_badvaddr_we = 1'b1;
                        cp0_badvaddr    = badvaddr_q;
                    end
                end
                state_d = StRedirect;
            end
            StRedirect: begin
                pipe_stall  = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = vec_target;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer: directed vector table,
// hand-written drain/reset sequences and randomized events vs a reference model.
module tb_exception_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        exc_req = 1'b0;
    logic [4:0]  exc_code = '0;
    logic [31:0] exc_badvaddr = '0;
    logic        exc_tlb_refill = 1'b0;
    logic        int_pending = 1'b0;
    logic        eret_req = 1'b0;
    logic        status_ie = 1'b0;
    logic        status_exl = 1'b0;
    logic        status_bev = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic [31:0] vic_inst_addr = '0;
    logic        vic_is_delayslot = 1'b0;
    logic [7:0]  exp_asid = '0;
    logic        mem_busy = 1'b0;
    logic        pipe_stall, pipe_flush, pc_redirect, cp0_exc_we, cp0_bd;
    logic        cp0_badvaddr_we, exl_set, exl_clr;
    logic [31:0] pc_target, cp0_epc_o, cp0_badvaddr;
    logic [4:0]  cp0_exccode;
    logic [7:0]  cp0_asid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    exception_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .exc_req          (exc_req),
        .exc_code         (exc_code),
        .exc_badvaddr     (exc_badvaddr),
        .exc_tlb_refill   (exc_tlb_refill),
        .int_pending      (int_pending),
        .eret_req         (eret_req),
        .status_ie        (status_ie),
        .status_exl       (status_exl),
        .status_bev       (status_bev),
        .cp0_epc          (cp0_epc),
        .vic_inst_addr    (vic_inst_addr),
        .vic_is_delayslot (vic_is_delayslot),
        .exp_asid         (exp_asid),
        .mem_busy         (mem_busy),
        .pipe_stall       (pipe_stall),
        .pipe_flush       (pipe_flush),
        .pc_redirect      (pc_redirect),
        .pc_target        (pc_target),
        .cp0_exc_we       (cp0_exc_we),
        .cp0_epc_o        (cp0_epc_o),
        .cp0_bd           (cp0_bd),
        .cp0_exccode      (cp0_exccode),
        .cp0_badvaddr     (cp0_badvaddr),
        .cp0_badvaddr_we  (cp0_badvaddr_we),
        .cp0_asid         (cp0_asid),
        .exl_set          (exl_set),
        .exl_clr          (exl_clr)
    );

    typedef struct {
        logic        exc;
        logic [4:0]  code;
        logic [31:0] bv;
        logic        refill;
        logic        intp;
        logic        eret;
        logic        ie;
        logic        exl;
        logic        bev;
        logic [31:0] epc;
        logic [31:0] vic;
        logic        ds;
        logic [7:0]  asid;
        int          busy;
    } vec_t;

    typedef struct {
        logic        we;
        logic        set;
        logic        clr;
        logic [31:0] epc;
        logic        bd;
        logic [4:0]  code;
        logic        bvwe;
        logic [31:0] bv;
        logic [7:0]  asid;
        logic [31:0] target;
    } exp_t;

    typedef struct {
        vec_t in;
        exp_t ex;
    } tv_t;

    tv_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: priority pick, then MIPS EPC/BD/BadVAddr/vector rules.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic [31:0] base;
        e = '{we: 0, set: 0, clr: 0, epc: 0, bd: 0, code: 0, bvwe: 0, bv: 0, asid: 0, target: 0};
        if (!v.exc && !(v.intp && v.ie && !v.exl) && v.eret) begin
            e.clr    = 1'b1;
            e.target = v.epc;
        end else begin
            e.we   = 1'b1;
            e.set  = 1'b1;
            e.code = v.exc ? v.code : 5'd0;
            e.epc  = v.ds ? v.vic - 32'd4 : v.vic;
            e.bd   = v.ds;
            e.asid = v.asid;
            if (e.code >= 5'd1 && e.code <= 5'd5) begin
                e.bvwe = 1'b1;
                e.bv   = v.bv;
            end
            base     = v.bev ? 32'hBFC00200 : 32'h80000000;
            e.target = base + ((v.exc && v.refill && !v.exl) ? 32'h0 : 32'h180);
        end
        return e;
    endfunction

    task automatic drive_idle_clear();
        exc_req = 0; int_pending = 0; eret_req = 0; exc_tlb_refill = 0;
    endtask

    // Requests seen outside IDLE must be ignored.
    task automatic drive_junk();
        exc_req = 1; int_pending = 1; eret_req = 1; exc_tlb_refill = $urandom % 2;
        exc_code = 5'($urandom); exc_badvaddr = $urandom; vic_inst_addr = $urandom;
        vic_is_delayslot = $urandom % 2; exp_asid = 8'($urandom); cp0_epc = $urandom;
        status_ie = $urandom % 2; status_exl = $urandom % 2;
    endtask

    task automatic run_vec(input string tag, input vec_t v, input exp_t e);
        @(negedge clk);
        exc_req = v.exc; exc_code = v.code; exc_badvaddr = v.bv; exc_tlb_refill = v.refill;
        int_pending = v.intp; eret_req = v.eret; status_ie = v.ie; status_exl = v.exl;
        status_bev = v.bev; cp0_epc = v.epc; vic_inst_addr = v.vic;
        vic_is_delayslot = v.ds; exp_asid = v.asid; mem_busy = (v.busy > 0);
        #1 chk({tag, ".stall_sel"}, 32'(pipe_stall), 1);
        for (int i = 0; i < v.busy; i++) begin
            @(negedge clk);
            drive_junk();
            mem_busy = (i < v.busy - 1);
            #1;
            chk({tag, ".drain_stall"}, 32'(pipe_stall), 1);
            chk({tag, ".drain_flush"}, 32'(pipe_flush), 0);
        end
        @(negedge clk);
        drive_junk();
        mem_busy = 1'b0;
        #1;
        chk({tag, ".flush"}, 32'(pipe_flush), 1);
        chk({tag, ".stall_c"}, 32'(pipe_stall), 1);
        chk({tag, ".exc_we"}, 32'(cp0_exc_we), 32'(e.we));
        chk({tag, ".exl_set"}, 32'(exl_set), 32'(e.set));
        chk({tag, ".exl_clr"}, 32'(exl_clr), 32'(e.clr));
        chk({tag, ".epc"}, cp0_epc_o, e.epc);
        chk({tag, ".bd"}, 32'(cp0_bd), 32'(e.bd));
        chk({tag, ".exccode"}, 32'(cp0_exccode), 32'(e.code));
        chk({tag, ".bv_we"}, 32'(cp0_badvaddr_we), 32'(e.bvwe));
        chk({tag, ".badvaddr"}, cp0_badvaddr, e.bv);
        chk({tag, ".asid"}, 32'(cp0_asid), 32'(e.asid));
        chk({tag, ".redir_c"}, 32'(pc_redirect), 0);
        @(negedge clk);
        drive_idle_clear();
        #1;
        chk({tag, ".redirect"}, 32'(pc_redirect), 1);
        chk({tag, ".target"}, pc_target, e.target);
        chk({tag, ".flush_r"}, 32'(pipe_flush), 0);
        chk({tag, ".we_r"}, 32'({cp0_exc_we, exl_set, exl_clr}), 0);
        @(negedge clk);
        #1;
        chk({tag, ".idle"}, 32'({pipe_stall, pc_redirect, pipe_flush}), 0);
    endtask

    initial begin
        int bad;
        vec_t rv;
        // exc intp eret ie exl bev ... ; expected: we set clr epc bd code bvwe bv asid target
        tbl[0] = '{'{1, 5'h04, 32'h00400003, 0, 0, 0, 0, 0, 1, 32'h0, 32'hBFC00010, 0, 8'h12, 0},
                   '{1, 1, 0, 32'hBFC00010, 0, 5'h04, 1, 32'h00400003, 8'h12, 32'hBFC00380}};
        tbl[1] = '{'{0, 5'h00, 32'h0, 0, 1, 0, 1, 0, 0, 32'h0, 32'h80001004, 1, 8'h34, 0},
                   '{1, 1, 0, 32'h80001000, 1, 5'h00, 0, 32'h0, 8'h34, 32'h80000180}};
        tbl[2] = '{'{1, 5'h08, 32'hDEADBEEF, 0, 1, 0, 1, 0, 0, 32'h0, 32'h80000400, 0, 8'h01, 0},
                   '{1, 1, 0, 32'h80000400, 0, 5'h08, 0, 32'h0, 8'h01, 32'h80000180}};
        tbl[3] = '{'{0, 5'h00, 32'h0, 0, 0, 1, 0, 1, 0, 32'h80002000, 32'h12345678, 1, 8'h55, 0},
                   '{0, 0, 1, 32'h0, 0, 5'h00, 0, 32'h0, 8'h00, 32'h80002000}};
        tbl[4] = '{'{1, 5'h02, 32'h00001000, 1, 0, 0, 0, 0, 0, 32'h0, 32'h00400020, 0, 8'h07, 0},
                   '{1, 1, 0, 32'h00400020, 0, 5'h02, 1, 32'h00001000, 8'h07, 32'h80000000}};
        tbl[5] = '{'{1, 5'h03, 32'h00002000, 1, 0, 0, 0, 1, 0, 32'h0, 32'h00400024, 0, 8'h08, 0},
                   '{1, 1, 0, 32'h00400024, 0, 5'h03, 1, 32'h00002000, 8'h08, 32'h80000180}};
        tbl[6] = '{'{0, 5'h00, 32'h0, 0, 1, 1, 1, 1, 0, 32'h80003004, 32'h00400000, 0, 8'h09, 0},
                   '{0, 0, 1, 32'h0, 0, 5'h00, 0, 32'h0, 8'h00, 32'h80003004}};
        tbl[7] = '{'{1, 5'h05, 32'h00000007, 0, 0, 0, 0, 0, 1, 32'h0, 32'h00000002, 1, 8'hFF, 0},
                   '{1, 1, 0, 32'hFFFFFFFE, 1, 5'h05, 1, 32'h00000007, 8'hFF, 32'hBFC00380}};
        tbl[8] = '{'{1, 5'h01, 32'h00ABCDEF, 0, 0, 0, 0, 0, 0, 32'h0, 32'h80000800, 0, 8'h3C, 4},
                   '{1, 1, 0, 32'h80000800, 0, 5'h01, 1, 32'h00ABCDEF, 8'h3C, 32'h80000180}};

        #3;
        chk("reset_outputs", 32'({pipe_stall, pipe_flush, pc_redirect, cp0_exc_we, exl_set,
            exl_clr, cp0_badvaddr_we}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1 chk("idle_after_reset", 32'(pipe_stall), 0);

        for (int i = 0; i < 9; i++) run_vec($sformatf("tbl%0d", i), tbl[i].in, tbl[i].ex);

        // Reset while draining abandons the event.
        @(negedge clk);
        exc_req = 1; exc_code = 5'h04; vic_inst_addr = 32'h80000010; mem_busy = 1;
        @(negedge clk);
        drive_idle_clear();
        #1 chk("rst.drain_stall", 32'(pipe_stall), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst.async_outputs", 32'({pipe_stall, pipe_flush, pc_redirect, cp0_exc_we, exl_set,
            exl_clr, cp0_badvaddr_we}), 0);
        chk("rst.async_data", cp0_epc_o | pc_target | cp0_badvaddr, 0);
        @(negedge clk);
        mem_busy = 0;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1 if (pc_redirect || cp0_exc_we || pipe_flush || exl_set || pipe_stall) bad++;
        end
        chk("rst.no_action_after", 32'(bad), 0);

        for (int i = 0; i < 40; i++) begin
            rv.exc    = ($urandom % 3) == 0;
            rv.code   = 5'($urandom);
            rv.bv     = $urandom;
            rv.refill = rv.exc && ($urandom % 2);
            rv.intp   = $urandom % 2;
            rv.eret   = $urandom % 2;
            rv.ie     = $urandom % 2;
            rv.exl    = $urandom % 2;
            rv.bev    = $urandom % 2;
            rv.epc    = $urandom;
            rv.vic    = $urandom;
            rv.ds     = $urandom % 2;
            rv.asid   = 8'($urandom);
            rv.busy   = $urandom_range(0, 3);
            if (!rv.exc && !(rv.intp && rv.ie && !rv.exl)) rv.eret = 1'b1;
            run_vec($sformatf("rnd%0d", i), rv, model(rv));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
